// File: rtl/resp_misr_capture_if.sv
// Response handshake bundle between the circuit under test and the capture stage.
//   resp_valid : producer has a response vector this cycle
//   resp_data  : response vector, bit i = circuit output i
//   resp_ready : capture stage accepts a vector this cycle
// Handshake: a beat transfers on a rising clock edge where resp_valid && resp_ready.
// resp_data is only looked at on such an edge, and the producer may drive anything otherwise.
interface resp_misr_capture_if #(
   parameter int WIDTH = 8
) ();
   logic             resp_valid;
   logic [WIDTH-1:0] resp_data;
   logic             resp_ready;

   modport master (output resp_valid, output resp_data, input resp_ready);
   modport slave  (input resp_valid, input resp_data, output resp_ready);
endinterface

// File: rtl/resp_misr_capture.sv
// Response-capture stage: folds one WIDTH-bit response vector per accepted beat
// into a SIG_W-bit MISR. After pat_count beats it enters DONE and reports whether
// the signature matches the golden value.
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start               single-cycle start pulse (ignored while a run is active)
//   pat_count, golden   run length and expected signature, sampled on an accepted start
//   resp                response handshake (slave side)
//   busy, done, pass    run active / run finished / signature matched golden (valid with done)
//   signature, count    current MISR contents and beats accepted since the last start
//   state_dbg           current FSM state (IDLE=0, RUN=1, DONE=2)
module resp_misr_capture #(
   parameter int               WIDTH = 8,
   parameter int               SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = 16'h100B,
   parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [SIG_W-1:0]            pat_count,
   input  logic [SIG_W-1:0]            golden,
   resp_misr_capture_if.slave          resp,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic [SIG_W-1:0]            signature,
   output logic [SIG_W-1:0]            count,
   output logic [1:0]                  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [SIG_W-1:0] sig_q, count_q, target_q, golden_q;
   logic             pass_q;
   logic             ready_w;
   logic             accept;
   logic             start_acc;
   logic             last_beat;
   logic [SIG_W-1:0] data_ext;
   logic [SIG_W-1:0] sig_next;
   logic [SIG_W-1:0] count_inc;

   // A run in progress cannot be restarted; only IDLE and DONE accept start.
   assign start_acc = start && (state_q != RUN);
   assign accept    = resp.resp_valid && ready_w;
   assign count_inc = count_q + {{(SIG_W-1){1'b0}}, 1'b1};
   assign last_beat = (count_inc == target_q);

   always_comb begin
      data_ext              = '0;
      data_ext[WIDTH-1:0]   = resp.resp_data;
   end

   // Galois-style shift with feedback from the MSB, then the response folded in.
   // Only loaded on an accepted beat, so an undriven resp_data never reaches sig_q.
   always_comb begin
      sig_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ data_ext;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ready_w = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = (pat_count != '0) ? RUN : DONE;
         end
         RUN: begin
            ready_w = 1'b1;
            busy    = 1'b1;
            if (accept && last_beat) state_d = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_d = (pat_count != '0) ? RUN : DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q    <= '0;
         count_q  <= '0;
         target_q <= '0;
         golden_q <= '0;
         pass_q   <= 1'b0;
      end else if (start_acc) begin
         sig_q    <= SEED;
         count_q  <= '0;
         target_q <= pat_count;
         golden_q <= golden;
         // A zero-length run lands in DONE immediately with the seed as signature.
         pass_q   <= (pat_count == '0) && (SEED == golden);
      end else if (accept) begin
         sig_q   <= sig_next;
         count_q <= count_inc;
         if (last_beat) pass_q <= (sig_next == golden_q);
      end
   end

   assign resp.resp_ready = ready_w;
   assign pass            = pass_q;
   assign signature       = sig_q;
   assign count           = count_q;
   assign state_dbg       = state_q;

endmodule

// File: tb/tb_resp_misr_capture.sv
module tb_resp_misr_capture;
   localparam int WIDTH = 8;
   localparam int SIG_W = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [SIG_W-1:0]  pat_count = '0;
   logic [SIG_W-1:0]  golden = '0;
   logic              busy, done, pass;
   logic [SIG_W-1:0]  signature, count;
   logic [1:0]        state_dbg;

   int n_tests = 0;
   int n_fail  = 0;

   resp_misr_capture_if #(.WIDTH(WIDTH)) resp ();

   resp_misr_capture #(.WIDTH(WIDTH), .SIG_W(SIG_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pat_count(pat_count), .golden(golden),
      .resp(resp.slave), .busy(busy), .done(done), .pass(pass),
      .signature(signature), .count(count), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, act=running exp=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // One MISR step in plain integer arithmetic: multiply by x modulo 2^16,
   // subtract (xor) the polynomial when x^16 overflowed, add the response.
   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] d);
      int v;
      v = (int'(s) * 2) % 65536;
      if (int'(s) >= 32768) v = v ^ 32'h100B;
      v = v ^ int'(d);
      return v[15:0];
   endfunction

   logic [15:0] m_sig = '0, m_count = '0, m_target = '0, m_gold = '0;
   bit          m_run = 1'b0, m_done = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sig = '0; m_count = '0; m_target = '0; m_gold = '0;
         m_run = 1'b0; m_done = 1'b0;
      end else if (start && !m_run) begin
         m_sig = 16'hFFFF; m_count = '0; m_target = pat_count; m_gold = golden;
         m_run = (pat_count != 0);
         m_done = (pat_count == 0);
      end else if (m_run && resp.resp_valid) begin
         m_sig = misr_step(m_sig, resp.resp_data);
         m_count = m_count + 16'd1;
         if (m_count == m_target) begin
            m_run = 1'b0;
            m_done = 1'b1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle, away from the active edge, all outputs against the model.
   always @(negedge clk) begin
      chk("cyc_ready", 32'(resp.resp_ready), 32'(m_run));
      chk("cyc_busy", 32'(busy), 32'(m_run));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_sig", 32'(signature), 32'(m_sig));
      chk("cyc_count", 32'(count), 32'(m_count));
      if (m_done) chk("cyc_pass", 32'(pass), 32'(m_sig == m_gold));
   end

   // ---------------- drivers ----------------
   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic start_run(input logic [15:0] pc, input logic [15:0] g);
      start = 1'b1; pat_count = pc; golden = g;
      resp.resp_valid = 1'b0;
      tick;
      start = 1'b0;
      pat_count = 16'($urandom);
      golden = 16'($urandom);
   endtask

   task automatic beat(input logic [7:0] d);
      resp.resp_valid = 1'b1;
      resp.resp_data = d;
      tick;
      resp.resp_valid = 1'b0;
      resp.resp_data = 8'($urandom);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0]  dq[$];
      logic [15:0] pred, g, pc;
      int sent, guard;
      bit was_acc;

      resp.resp_valid = 1'b0;
      resp.resp_data = '0;
      tick; tick;
      chk("rst_sig", 32'(signature), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_ready", 32'(resp.resp_ready), 32'h0);
      chk("rst_flags", {busy, done, pass}, 32'h0);
      rst_n = 1'b1;
      tick;

      // single beat of zero against the matching golden
      start_run(16'd1, 16'hEFF5);
      beat(8'h00);
      chk("s1_sig", 32'(signature), 32'hEFF5);
      chk("s1_count", 32'(count), 32'd1);
      chk("s1_done", 32'(done), 32'd1);
      chk("s1_pass", 32'(pass), 32'd1);

      // restart from DONE; data A5 spoils the match
      start_run(16'd1, 16'hEFF5);
      chk("s2_done_drop", {done, pass, busy}, 32'b001);
      beat(8'hA5);
      chk("s2_sig", 32'(signature), 32'hEF50);
      chk("s2_pass", 32'(pass), 32'd0);

      // two back-to-back beats, then valid in DONE is ignored
      start_run(16'd2, 16'hCFE1);
      beat(8'h00);
      chk("s3_mid_sig", 32'(signature), 32'hEFF5);
      chk("s3_mid_done", 32'(done), 32'd0);
      beat(8'h00);
      chk("s3_sig", 32'(signature), 32'hCFE1);
      chk("s3_done_pass", {done, pass}, 32'b11);
      resp.resp_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         resp.resp_data = 8'($urandom);
         tick;
      end
      resp.resp_valid = 1'b0;
      chk("s3_frozen_sig", 32'(signature), 32'hCFE1);
      chk("s3_frozen_count", 32'(count), 32'd2);

      // stall gap between the two beats
      start_run(16'd2, 16'h0000);
      beat(8'h00);
      for (int i = 0; i < 3; i++) begin
         resp.resp_data = 8'($urandom);
         tick;
         chk("s4_gap_busy", 32'(busy), 32'd1);
      end
      beat(8'h00);
      chk("s4_sig", 32'(signature), 32'hCFE1);
      chk("s4_count", 32'(count), 32'd2);
      chk("s4_pass", 32'(pass), 32'd0);

      // zero-length runs
      start_run(16'd0, 16'hFFFF);
      chk("s5_done", 32'(done), 32'd1);
      chk("s5_sig", 32'(signature), 32'hFFFF);
      chk("s5_pass", 32'(pass), 32'd1);
      start_run(16'd0, 16'h1234);
      chk("s5b_pass", 32'(pass), 32'd0);

      // start during RUN is ignored
      start_run(16'd3, 16'h0000);
      beat(8'h11);
      start = 1'b1; pat_count = 16'd1; golden = 16'hFFFF;
      tick;
      start = 1'b0;
      beat(8'h22);
      chk("s5c_count", 32'(count), 32'd2);
      chk("s5c_done", 32'(done), 32'd0);
      beat(8'h33);
      chk("s5c_final_done", 32'(done), 32'd1);
      chk("s5c_final_count", 32'(count), 32'd3);

      // asynchronous reset mid-run
      start_run(16'd5, 16'hEFF5);
      beat(8'h3C);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("s6_sig", 32'(signature), 32'h0);
      chk("s6_count", 32'(count), 32'h0);
      chk("s6_ready", 32'(resp.resp_ready), 32'h0);
      chk("s6_done", 32'(done), 32'h0);
      tick;
      rst_n = 1'b1;
      tick;
      chk("s6_idle", {busy, done}, 32'h0);
      // start together with valid in IDLE: data must not be absorbed
      start = 1'b1; pat_count = 16'd1; golden = 16'hEFF5;
      resp.resp_valid = 1'b1; resp.resp_data = 8'hFF;
      tick;
      start = 1'b0; resp.resp_valid = 1'b0;
      chk("s6_start_sig", 32'(signature), 32'hFFFF);
      chk("s6_start_count", 32'(count), 32'd0);
      beat(8'h00);
      chk("s6_sig_again", 32'(signature), 32'hEFF5);
      chk("s6_pass_again", {done, pass}, 32'b11);

      // randomized runs
      for (int r = 0; r < 40; r++) begin
         pc = 16'($urandom_range(0, 12));
         dq.delete();
         pred = 16'hFFFF;
         for (int k = 0; k < int'(pc); k++) begin
            dq.push_back(8'($urandom));
            pred = misr_step(pred, dq[k]);
         end
         g = ($urandom_range(0, 1) == 1) ? pred : 16'($urandom);
         start_run(pc, g);
         sent = 0;
         guard = 0;
         while (sent < int'(pc) && guard < 400) begin
            if ($urandom_range(0, 3) != 0) begin
               resp.resp_valid = 1'b1;
               resp.resp_data = dq[sent];
            end else begin
               resp.resp_valid = 1'b0;
               resp.resp_data = 8'($urandom);
            end
            if ($urandom_range(0, 9) == 0) begin
               start = 1'b1;
               pat_count = 16'($urandom_range(1, 5));
            end
            was_acc = resp.resp_valid && resp.resp_ready;
            tick;
            start = 1'b0;
            resp.resp_valid = 1'b0;
            if (was_acc) sent++;
            guard++;
         end
         chk("rnd_run_complete", 32'(sent), 32'(pc));
         chk("rnd_sig", 32'(signature), 32'(pred));
         chk("rnd_done", 32'(done), 32'd1);
         chk("rnd_pass", 32'(pass), 32'(g == pred));
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            resp.resp_valid = 1'($urandom);
            resp.resp_data = 8'($urandom);
            tick;
         end
         resp.resp_valid = 1'b0;
      end

      tick;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/resp_misr_capture.md
# resp_misr_capture

Downstream response-capture stage for the combinational test circuit. Consumes the circuit's 8-bit output vector one pattern per handshake beat and compresses the vectors into a 16-bit multiple-input signature register (MISR). After a programmed number of patterns it raises `done` and compares the signature with a golden value. Sits between the circuit under test and the test controller / ECO-equivalence checker.

## Interface
- `WIDTH`, 8: response vector width; must be ≤ `SIG_W`.
- `SIG_W`, 16: signature and counter width.
- `POLY`, 16'h100B: feedback polynomial x^16+x^12+x^3+x+1 (bit k set = tap x^k).
- `SEED`, 16'hFFFF: signature value loaded on `start`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle start pulse.
- `pat_count`  in  SIG_W  number of patterns; sampled on accepted `start`.
- `golden`  in  SIG_W  expected signature; sampled on accepted `start`.
- `resp_valid`  in  1  response vector valid.
- `resp_data`  in  WIDTH  response vector, bit i = circuit output i.
- `resp_ready`  out  1  block accepts a response this cycle.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  `signature == golden_q`; meaningful only while `done`.
- `signature`  out  SIG_W  current MISR contents.
- `count`  out  SIG_W  responses accepted since last start.

## Operation
- States: IDLE, RUN, DONE; registered state, Moore outputs.
- Reset (async, `rst_n`=0): state=IDLE; `signature`=0, `count`=0, target=0, golden_q=0; `resp_ready`=`busy`=`done`=`pass`=0.
- IDLE: `resp_ready`=0. `resp_valid` is ignored.
- `start` in IDLE or DONE: signature←SEED, count←0, target←`pat_count`, golden_q←`golden`.
  - If `pat_count`≠0, go to RUN.
  - If `pat_count`=0, go directly to DONE; `signature` stays at SEED.
- `start` in RUN is ignored. There is no abort; only reset ends a run.
- RUN: `resp_ready`=1 and `busy`=1. A beat is accepted when `resp_valid && resp_ready`. On each accepted beat:
  - sig_next = ({sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0)) ^ zero-extended `resp_data`.
  - count ← count+1.
- The beat that makes count equal target is the last beat: the state moves to DONE on that same edge.
- `resp_valid`=0 in RUN stalls the block. Signature and count hold, with no timeout.
- DONE: `done`=1, `resp_ready`=0. Signature and count are frozen.
  - `pass` is registered and equals (final signature == golden_q) from the first DONE cycle onward.
  - The block stays in DONE until `start` or reset.
- Counter never wraps, because target ≤ 2^SIG_W−1 and the run ends at target.
- `resp_data` is don't-care when no beat is accepted. X on an unaccepted `resp_data` must not propagate into the signature.

## Timing
- `start` at edge t: state RUN (or DONE) and `resp_ready`=1 visible after edge t. The earliest beat is accepted at edge t+1.
- One beat per cycle at full throughput. A run of N back-to-back patterns takes N cycles.
- Last beat accepted at edge t: `done`=1, `pass` valid and `resp_ready`=0 after edge t.
- `start` and `resp_valid` in the same IDLE cycle: only the start takes effect; the data is not absorbed.
- `start` in DONE: `done` and `pass` drop after that edge, and the new run begins.
- Reset asserted mid-RUN: all outputs take their reset values immediately (asynchronously). After release the block is in IDLE.

## Test plan
- Reset, then `start` with pat_count=1 and golden=16'hEFF5, one beat resp_data=8'h00 → signature=16'hEFF5, count=1, done=1, pass=1 one cycle after the beat.
- Same run with resp_data=8'hA5 and golden=16'hEFF5 → signature=16'hEF50, pass=0.
- pat_count=2, two back-to-back beats of 8'h00 → intermediate signature 16'hEFF5, final 16'hCFE1, done exactly after the 2nd accepting edge. Then apply `resp_valid` in DONE → no change.
- pat_count=2 with `resp_valid` low for 3 cycles between the two beats → final 16'hCFE1 and count=2; `busy` stays high during the gap.
- pat_count=0 → DONE the cycle after `start`, signature=16'hFFFF, pass=(golden==16'hFFFF). `start` pulsed in RUN is ignored: count and target are unchanged.
- Assert `rst_n` low mid-RUN after 1 beat → signature=0, count=0, resp_ready=0, done=0 immediately, without waiting for a clock edge. After release, a fresh `start` run reproduces the first scenario.
